// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state type and constants for the instruction fetch controller
// Contents: fetch_state_t (IDLE/BUSY/HOLD/FAULT), TIMEOUT_DEFAULT, INSTR_BYTES
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, HOLD, FAULT} fetch_state_t;
    localparam int TIMEOUT_DEFAULT = 16;
    localparam int INSTR_BYTES     = 4;
endpackage

// File: rtl/fetch_timer.sv
// fetch_timer: counts cycles spent waiting for memory and flags the last allowed one
// Ports: Clk, Rst (sync, active-low), clear (zero the count), enable (count this cycle),
//        expired (high on the TIMEOUT-th enabled cycle since the last clear)
module fetch_timer import fetch_pkg::*; #(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge Clk) begin
        if (!Rst || clear)
            r_cnt <= '0;
        else if (enable)
            r_cnt <= r_cnt + CW'(1);
    end
    assign expired = enable && (r_cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: one-instruction-at-a-time fetch FSM between the PC, instruction memory and decode
// Ports: Clk, Rst (sync, active-low); pc_q in, pc_next/pc_en out (PC load);
//        mem_req/mem_addr out, mem_ack/mem_rdata/mem_err in (memory read);
//        instr_valid/instr out, instr_ready in (decode handshake);
//        branch_taken/branch_target in (redirect on handshake); fetch_fault/fault_addr out (sticky)
module fetch_ctrl import fetch_pkg::*; #(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int ADDR_W  = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] pc_q,
    output logic [ADDR_W-1:0] pc_next,
    output logic              pc_en,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [ADDR_W-1:0] mem_rdata,
    input  logic              mem_err,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr,
    input  logic              instr_ready,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              fetch_fault,
    output logic [ADDR_W-1:0] fault_addr
);
    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_fault_addr;
    logic              r_fault;
    logic              w_busy;
    logic              w_expired;

    assign w_busy = (r_state == BUSY);

    fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .Clk     (Clk),
        .Rst     (Rst),
        .clear   (!w_busy),
        .enable  (w_busy),
        .expired (w_expired)
    );

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state      <= IDLE;
            r_instr      <= '0;
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_addr <= pc_q;
                    if (pc_q[1:0] != 2'b00) begin
                        r_state      <= FAULT;
                        r_fault      <= 1'b1;
                        r_fault_addr <= pc_q;
                    end else begin
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    // an ack arriving on the expiry cycle takes priority over the timeout
                    if (mem_ack && !mem_err) begin
                        r_instr <= mem_rdata;
                        r_state <= HOLD;
                    end else if (mem_ack || w_expired) begin
                        r_state      <= FAULT;
                        r_fault      <= 1'b1;
                        r_fault_addr <= r_addr;
                    end
                end
                HOLD: begin
                    if (instr_ready)
                        r_state <= IDLE;
                end
                default: r_state <= FAULT;
            endcase
        end
    end

    // request/valid/enable are gated by Rst so they drop as soon as reset is asserted
    assign mem_req     = Rst && w_busy;
    assign mem_addr    = r_addr;
    assign instr_valid = Rst && (r_state == HOLD);
    assign instr       = r_instr;
    assign pc_en       = instr_valid && instr_ready;
    assign pc_next     = branch_taken ? branch_target : r_addr + ADDR_W'(INSTR_BYTES);
    assign fetch_fault = r_fault;
    assign fault_addr  = r_fault_addr;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: table-driven, hand-sequenced and randomized checks of fetch_ctrl
module tb_fetch_ctrl;
    localparam int T = 16;

    logic        Clk;
    logic        Rst;
    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic        pc_en;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        fetch_fault;
    logic [31:0] fault_addr;

    int checks = 0;
    int failures = 0;

    fetch_ctrl #(.TIMEOUT(T), .ADDR_W(32)) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .pc_q          (pc_q),
        .pc_next       (pc_next),
        .pc_en         (pc_en),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .mem_err       (mem_err),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .fetch_fault   (fetch_fault),
        .fault_addr    (fault_addr)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic [31:0] addr;
        int          lat;
        logic [31:0] data;
        logic        err;
        int          rdy;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] npc;
        logic        flt;
        logic [31:0] fa;
        int          cyc;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, a, e);
        end
    endtask

    task automatic chk_b(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", n, a, e);
        end
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        mem_ack = 1'b1;
        mem_err = 1'b0;
        instr_ready = 1'b1;
        branch_taken = 1'b0;
        #1;
        chk_b("rst_req", mem_req, 1'b0);
        chk_b("rst_valid", instr_valid, 1'b0);
        chk_b("rst_pcen", pc_en, 1'b0);
        @(negedge Clk);
        chk("rst_instr", instr, 32'h0);
        chk_b("rst_fault", fetch_fault, 1'b0);
        chk("rst_faddr", fault_addr, 32'h0);
        Rst = 1'b1;
        mem_ack = 1'b0;
    endtask

    // One complete fetch, starting with the DUT in IDLE; expectations come from the fetch rules
    task automatic fetch(input logic [31:0] addr, input int lat, input logic [31:0] data,
                         input logic err, input int rdy, input logic br, input logic [31:0] tgt,
                         output logic [31:0] npc, output logic flt, output logic [31:0] fa,
                         output int cyc);
        logic [31:0] e;
        logic bad;
        npc = '0;
        flt = 1'b0;
        fa = '0;
        cyc = 0;
        bad = (addr[1:0] != 2'b00);
        pc_q = addr;
        mem_ack = 1'b1;
        mem_err = 1'($urandom);
        mem_rdata = $urandom;
        instr_ready = 1'b1;
        branch_taken = 1'b1;
        branch_target = $urandom;
        #1;
        chk_b("idle_req", mem_req, 1'b0);
        chk_b("idle_valid", instr_valid, 1'b0);
        chk_b("idle_pcen", pc_en, 1'b0);
        chk_b("idle_fault", fetch_fault, 1'b0);
        @(negedge Clk);
        cyc++;
        if (!bad) begin
            for (int k = 0; k < T; k++) begin
                mem_ack = (k == lat);
                mem_err = err;
                mem_rdata = (k == lat) ? data : $urandom;
                instr_ready = 1'($urandom);
                branch_taken = 1'($urandom);
                pc_q = $urandom;
                #1;
                chk_b("busy_req", mem_req, 1'b1);
                chk("busy_addr", mem_addr, addr);
                chk_b("busy_valid", instr_valid, 1'b0);
                chk_b("busy_pcen", pc_en, 1'b0);
                @(negedge Clk);
                cyc++;
                if (k == lat) break;
            end
            mem_ack = 1'b0;
            bad = (lat >= T) || err;
        end
        if (bad) begin
            for (int j = 0; j < 3; j++) begin
                mem_ack = 1'b1;
                mem_err = 1'b0;
                instr_ready = 1'b1;
                branch_taken = 1'($urandom);
                pc_q = $urandom & 32'hFFFF_FFFC;
                #1;
                chk_b("flt_flag", fetch_fault, 1'b1);
                chk("flt_addr", fault_addr, addr);
                chk_b("flt_req", mem_req, 1'b0);
                chk_b("flt_pcen", pc_en, 1'b0);
                chk_b("flt_valid", instr_valid, 1'b0);
                @(negedge Clk);
            end
            flt = fetch_fault;
            fa = fault_addr;
            mem_ack = 1'b0;
        end else begin
            e = br ? tgt : addr + 32'd4;
            for (int j = 0; j <= rdy; j++) begin
                instr_ready = (j == rdy);
                branch_taken = (j == rdy) ? br : 1'($urandom);
                branch_target = (j == rdy) ? tgt : $urandom;
                mem_ack = 1'($urandom);
                mem_err = 1'($urandom);
                mem_rdata = $urandom;
                #1;
                chk_b("hold_valid", instr_valid, 1'b1);
                chk("hold_instr", instr, data);
                chk_b("hold_req", mem_req, 1'b0);
                chk_b("hold_pcen", pc_en, j == rdy);
                chk_b("hold_fault", fetch_fault, 1'b0);
                if (j == rdy) begin
                    chk("hold_pcnext", pc_next, e);
                    npc = pc_next;
                end
                @(negedge Clk);
                cyc++;
            end
            mem_ack = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] npc, fa, m, tgt, enpc;
        logic flt, err, br, efault, need_rst;
        int cyc, lat, rdy;
        Rst = 1'b0;
        pc_q = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        mem_err = 1'b0;
        instr_ready = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;

        //          addr          lat data          err  rdy br   tgt           npc           flt  fa            cyc
        tbl[0] = '{32'h0000_0000, 0,  32'h1234_5678, 1'b0, 0, 1'b0, 32'h0,        32'h0000_0004, 1'b0, 32'h0,        3};
        tbl[1] = '{32'h0000_0004, 4,  32'hA5A5_0001, 1'b0, 3, 1'b0, 32'h0,        32'h0000_0008, 1'b0, 32'h0,        10};
        tbl[2] = '{32'h0000_0008, 1,  32'h0BAD_CAFE, 1'b0, 1, 1'b1, 32'h0000_0100, 32'h0000_0100, 1'b0, 32'h0,        5};
        tbl[3] = '{32'hFFFF_FFFC, 2,  32'h7777_0003, 1'b0, 0, 1'b0, 32'h0,        32'h0000_0000, 1'b0, 32'h0,        5};
        tbl[4] = '{32'h0000_0100, 15, 32'h5555_AAAA, 1'b0, 0, 1'b1, 32'h0000_0102, 32'h0000_0102, 1'b0, 32'h0,        18};
        tbl[5] = '{32'h0000_0102, 0,  32'h0,        1'b0, 0, 1'b0, 32'h0,        32'h0,        1'b1, 32'h0000_0102, 0};
        tbl[6] = '{32'h0000_0006, 0,  32'h0,        1'b0, 0, 1'b0, 32'h0,        32'h0,        1'b1, 32'h0000_0006, 0};
        tbl[7] = '{32'h0000_0040, 3,  32'h0,        1'b1, 0, 1'b0, 32'h0,        32'h0,        1'b1, 32'h0000_0040, 0};
        tbl[8] = '{32'h0000_0080, 99, 32'h0,        1'b0, 0, 1'b0, 32'h0,        32'h0,        1'b1, 32'h0000_0080, 0};

        do_reset();
        need_rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (need_rst) do_reset();
            fetch(tbl[i].addr, tbl[i].lat, tbl[i].data, tbl[i].err, tbl[i].rdy, tbl[i].br,
                  tbl[i].tgt, npc, flt, fa, cyc);
            chk_b($sformatf("v%0d_fault", i), flt, tbl[i].flt);
            if (tbl[i].flt) begin
                chk($sformatf("v%0d_faddr", i), fa, tbl[i].fa);
            end else begin
                chk($sformatf("v%0d_npc", i), npc, tbl[i].npc);
                chk($sformatf("v%0d_cycles", i), cyc, tbl[i].cyc);
            end
            need_rst = tbl[i].flt;
        end

        // reset asserted in the middle of BUSY, ack arrives afterwards
        do_reset();
        pc_q = 32'h0000_0080;
        mem_ack = 1'b0;
        #1;
        chk_b("abort_idle_req", mem_req, 1'b0);
        @(negedge Clk);
        #1;
        chk_b("abort_busy_req", mem_req, 1'b1);
        chk("abort_busy_addr", mem_addr, 32'h0000_0080);
        Rst = 1'b0;
        #1;
        chk_b("abort_rst_req", mem_req, 1'b0);
        @(negedge Clk);
        chk("abort_instr", instr, 32'h0);
        chk_b("abort_fault", fetch_fault, 1'b0);
        Rst = 1'b1;
        fetch(32'h0000_0200, 1, 32'hCAFE_F00D, 1'b0, 0, 1'b0, 32'h0, npc, flt, fa, cyc);
        chk("abort_restart_npc", npc, 32'h0000_0204);
        chk("abort_restart_cycles", cyc, 32'd4);

        // randomized fetch stream against the rule-level expectations
        do_reset();
        m = $urandom & 32'hFFFF_FFFC;
        for (int n = 0; n < 60; n++) begin
            lat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 5));
            err = ($urandom_range(0, 9) == 0);
            rdy = int'($urandom_range(0, 3));
            br = ($urandom_range(0, 3) == 0);
            tgt = $urandom & (($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            efault = (m[1:0] != 2'b00) || (lat >= T) || err;
            fetch(m, lat, $urandom, err, rdy, br, tgt, npc, flt, fa, cyc);
            chk_b("rnd_fault", flt, efault);
            if (efault) begin
                chk("rnd_faddr", fa, m);
                do_reset();
                m = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            end else begin
                enpc = br ? tgt : m + 32'd4;
                chk("rnd_npc", npc, enpc);
                m = enpc;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum number of BUSY cycles allowed without mem_ack before a fault.
REQ-002 Parameter ADDR_W, default 32, SHALL set the address and data width.
REQ-003 Clk  input  1  SHALL be the clock; all state changes occur on the rising edge.
REQ-004 Rst  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 pc_q  input  32  SHALL carry the current program counter value.
REQ-006 pc_next  output  32  SHALL carry the value to load into the program counter.
REQ-007 pc_en  output  1  SHALL be the program-counter load enable; pc_next is loaded on the edge where pc_en=1.
REQ-008 mem_req  output  1  SHALL be the instruction-memory read request.
REQ-009 mem_addr  output  32  SHALL carry the instruction-memory read address.
REQ-010 mem_ack  input  1  SHALL indicate that mem_rdata/mem_err are valid this cycle.
REQ-011 mem_rdata  input  32  SHALL carry the returned instruction word.
REQ-012 mem_err  input  1  SHALL flag a memory access error; qualified by mem_ack.
REQ-013 instr_valid / instr  output  1 / 32  SHALL present the fetched instruction to decode.
REQ-014 instr_ready  input  1  SHALL indicate that decode accepts instr this cycle.
REQ-015 branch_taken / branch_target  input  1 / 32  SHALL select a redirect target; sampled only on handshake.
REQ-016 fetch_fault / fault_addr  output  1 / 32  SHALL provide a sticky fault flag and the faulting address.

Function
REQ-017 FSM states SHALL be IDLE, BUSY, HOLD, FAULT.
REQ-018 IDLE behaviour: latch pc_q into the internal address register; if pc_q[1:0]!=0, go to FAULT; otherwise go to BUSY.
REQ-019 BUSY behaviour: mem_req=1 and mem_addr=latched address, decoded combinationally from state; mem_req stays high until mem_ack.
REQ-020 BUSY with mem_ack=1 and mem_err=0: capture mem_rdata into instr and go to HOLD.
REQ-021 BUSY with mem_ack=1 and mem_err=1: go to FAULT.
REQ-022 BUSY timeout: if the cycle counter reaches TIMEOUT without mem_ack, go to FAULT; mem_ack on the expiry cycle wins.
REQ-023 HOLD behaviour: instr_valid=1 and instr is held stable until instr_ready=1.
REQ-024 HOLD with instr_ready=1: pc_en=1 combinationally in that cycle; next state IDLE.
REQ-025 pc_next selection: pc_next = branch_taken ? branch_target : addr+4.
REQ-026 pc_next arithmetic: addr+4 SHALL be modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
REQ-027 pc_en SHALL be 0 in every state other than HOLD with instr_ready=1.
REQ-028 Minimum latency SHALL be 3 cycles per instruction (IDLE, BUSY with same-cycle ack, HOLD with ready).
REQ-029 mem_ack outside BUSY SHALL be ignored.
REQ-030 branch_taken outside the HOLD handshake SHALL be ignored.
REQ-031 A misaligned branch_target SHALL be loaded unchanged; the fault is raised at the next IDLE.
REQ-032 FAULT behaviour: fetch_fault=1 and fault_addr=latched address; mem_req=0, pc_en=0, instr_valid=0.
REQ-033 FAULT SHALL be held until reset.

Reset
REQ-034 On a Clk edge with Rst=0: state=IDLE, counter=0, instr=0, fault_addr=0, fetch_fault=0.
REQ-035 While Rst=0, mem_req, pc_en and instr_valid SHALL be 0.
REQ-036 Reset during BUSY or HOLD SHALL abort the transfer; a late mem_ack SHALL be ignored.

Structure
REQ-037 Package fetch_pkg SHALL hold the state enum, the TIMEOUT default and INSTR_BYTES=4.
REQ-038 The BUSY timeout counter SHALL be the sub-module fetch_timer (clear, enable, expired).

Verification
REQ-039 Reset, then pc_q=0 with mem_ack in the first BUSY cycle and rdata=0x12345678, instr_ready=1 -> instr=0x12345678, pc_en=1, pc_next=0x4 on cycle 3.
REQ-040 mem_ack delayed 5 cycles with instr_ready low for 3 cycles -> mem_req high for exactly 5 cycles, instr stable throughout, one pc_en pulse.
REQ-041 Handshake with branch_taken=1 and branch_target=0x100 -> pc_next=0x100; with pc_q=0xFFFFFFFC and no branch -> pc_next=0x0.
REQ-042 pc_q=0x6 -> FAULT with no mem_req; mem_err on ack at addr 0x40 -> fault_addr=0x40; no ack for 16 cycles -> fetch_fault=1.
REQ-043 Rst=0 during BUSY, then mem_ack -> outputs at reset values, ack ignored, fetch restarts at the pc_q value.
